// File: rtl/pcap_to_hwgen_pkg.sv
// Shared definitions for the pcap_to_hwgen parser.
//   - pcap_state_e   : parser FSM states
//   - PCAP_MAGIC_LE  : first four file bytes as a little-endian word
//   - header sizes, descriptor field offsets
//   - rec_hdr_t      : record header laid out so that a 16-byte little-endian
//                      slice of the byte buffer casts directly onto it
//   - build_desc     : packs a record header into the outgoing descriptor
//   - keep_low_bytes : zeroes every byte at or above a given count
package pcap_to_hwgen_pkg;

  typedef enum logic [2:0] {
    ST_GLOBAL,
    ST_REC_HDR,
    ST_EMIT_HDR,
    ST_DATA,
    ST_ERROR
  } pcap_state_e;

  localparam logic [31:0] PCAP_MAGIC_LE    = 32'hA1B2_C3D4;
  localparam int unsigned GLOBAL_HDR_BYTES = 24;
  localparam int unsigned REC_HDR_BYTES    = 16;
  localparam int unsigned WORD_BYTES       = 16;

  localparam int unsigned DESC_INCL_LSB = 0;
  localparam int unsigned DESC_ORIG_LSB = 32;
  localparam int unsigned DESC_USEC_LSB = 64;
  localparam int unsigned DESC_SEC_LSB  = 96;

  // Member order is MSB first, so ts_sec lands on bytes 0..3 of the slice.
  typedef struct packed {
    logic [31:0] orig_len;
    logic [31:0] incl_len;
    logic [31:0] ts_usec;
    logic [31:0] ts_sec;
  } rec_hdr_t;

  function automatic logic [127:0] build_desc(input rec_hdr_t h);
    logic [127:0] d;
    d = '0;
    d[DESC_INCL_LSB +: 32] = h.incl_len;
    d[DESC_ORIG_LSB +: 32] = h.orig_len;
    d[DESC_USEC_LSB +: 32] = h.ts_usec;
    d[DESC_SEC_LSB  +: 32] = h.ts_sec;
    return d;
  endfunction

  function automatic logic [127:0] keep_low_bytes(input logic [127:0] w, input logic [4:0] n);
    logic [127:0] r;
    r = w;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (i >= 32'(n)) r[8*i +: 8] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pcap_byte_aligner.sv
// 32-byte shift buffer between the 16-byte input beats and the parser.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : input beat valid
//   in_ready   : input beat accepted (room for a full beat, or discarding)
//   in_data    : 16 input bytes, byte 0 in the LSBs
//   discard    : accept and drop every beat (parser in its error state)
//   consume    : bytes removed from the bottom this cycle (never above fill)
//   fill       : number of valid bytes held, 0..32
//   head       : lowest 16 buffered bytes, byte 0 in the LSBs
module pcap_byte_aligner
  import pcap_to_hwgen_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         discard,
  input  logic [4:0]   consume,
  output logic [5:0]   fill,
  output logic [127:0] head
);

  logic [255:0] bytes_q, bytes_d;
  logic [5:0]   fill_q, fill_d;
  logic [5:0]   keep;
  logic         append;

  always_comb begin
    // fill <= 16 guarantees a beat fits even when nothing is consumed.
    in_ready = (rst_n && (fill_q <= 6'd16)) || discard;
    append   = in_valid && in_ready && !discard;
    keep     = fill_q - {1'b0, consume};

    // Bytes above fill are kept zero, so the new beat can simply be OR'ed in.
    bytes_d = bytes_q >> {consume, 3'b000};
    if (append) begin
      bytes_d = bytes_d | ({128'b0, in_data} << {keep, 3'b000});
    end
    fill_d = keep + (append ? 6'd16 : 6'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_q <= '0;
      fill_q  <= '0;
    end else begin
      bytes_q <= bytes_d;
      fill_q  <= fill_d;
    end
  end

  assign fill = fill_q;
  assign head = bytes_q[127:0];

endmodule

// File: rtl/pcap_to_hwgen.sv
// Converts a raw libpcap file image into descriptor + payload words.
//   CLK, RST_N    : clock, asynchronous active-low reset
//   PCAP_TVALID   : input beat valid
//   PCAP_TREADY   : input beat accepted when TVALID && TREADY
//   PCAP_TDATA    : 16 file bytes per beat, byte 0 in the LSBs
//   HWGEN_TVALID  : output word valid (registered)
//   HWGEN_TREADY  : downstream ready
//   HWGEN_TDATA   : descriptor {ts_sec, ts_usec, orig_len, incl_len} or
//                   up to 16 payload bytes, unused upper bytes zero
// Per packet one descriptor is emitted followed by ceil(incl_len/16) words.
// A bad magic or an oversized incl_len locks the parser in ST_ERROR, where
// input is swallowed and nothing further is emitted until reset.
module pcap_to_hwgen
  import pcap_to_hwgen_pkg::*;
#(
  parameter int unsigned MAX_PKT_LEN = 16384
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         PCAP_TVALID,
  output logic         PCAP_TREADY,
  input  logic [127:0] PCAP_TDATA,
  output logic         HWGEN_TVALID,
  input  logic         HWGEN_TREADY,
  output logic [127:0] HWGEN_TDATA
);

  pcap_state_e  state_q, state_d;
  rec_hdr_t     hdr_q, hdr_d;
  logic [31:0]  remaining_q, remaining_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_data_q, out_data_d;

  logic [4:0]   consume;
  logic [5:0]   fill;
  logic [127:0] head;
  logic         can_load;
  logic [4:0]   n_bytes;

  pcap_byte_aligner u_aligner (
    .clk      (CLK),
    .rst_n    (RST_N),
    .in_valid (PCAP_TVALID),
    .in_ready (PCAP_TREADY),
    .in_data  (PCAP_TDATA),
    .discard  (state_q == ST_ERROR),
    .consume  (consume),
    .fill     (fill),
    .head     (head)
  );

  always_comb begin
    can_load    = !out_valid_q || HWGEN_TREADY;
    n_bytes     = (remaining_q >= 32'(WORD_BYTES)) ? 5'(WORD_BYTES) : remaining_q[4:0];

    state_d     = state_q;
    hdr_d       = hdr_q;
    remaining_d = remaining_q;
    // A presented word retires on TREADY; loads below re-assert valid.
    out_valid_d = out_valid_q && !HWGEN_TREADY;
    out_data_d  = out_data_q;
    consume     = '0;

    unique case (state_q)
      ST_GLOBAL: begin
        if (fill >= 6'(GLOBAL_HDR_BYTES)) begin
          consume = 5'(GLOBAL_HDR_BYTES);
          state_d = (head[31:0] == PCAP_MAGIC_LE) ? ST_REC_HDR : ST_ERROR;
        end
      end
      ST_REC_HDR: begin
        if (fill >= 6'(REC_HDR_BYTES)) begin
          consume = 5'(REC_HDR_BYTES);
          hdr_d   = rec_hdr_t'(head);
          state_d = (hdr_d.incl_len > 32'(MAX_PKT_LEN)) ? ST_ERROR : ST_EMIT_HDR;
        end
      end
      ST_EMIT_HDR: begin
        if (can_load) begin
          out_valid_d = 1'b1;
          out_data_d  = build_desc(hdr_q);
          remaining_d = hdr_q.incl_len;
          state_d     = (hdr_q.incl_len == '0) ? ST_REC_HDR : ST_DATA;
        end
      end
      ST_DATA: begin
        if (can_load && (fill >= {1'b0, n_bytes})) begin
          out_valid_d = 1'b1;
          out_data_d  = keep_low_bytes(head, n_bytes);
          consume     = n_bytes;
          remaining_d = remaining_q - 32'(n_bytes);
          if (remaining_q == 32'(n_bytes)) state_d = ST_REC_HDR;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_GLOBAL;
      hdr_q       <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign HWGEN_TVALID = out_valid_q;
  assign HWGEN_TDATA  = out_data_q;

endmodule

// File: tb/tb_pcap_to_hwgen.sv
module tb_pcap_to_hwgen;

  logic         CLK;
  logic         RST_N;
  logic         PCAP_TVALID;
  logic         PCAP_TREADY;
  logic [127:0] PCAP_TDATA;
  logic         HWGEN_TVALID;
  logic         HWGEN_TREADY;
  logic [127:0] HWGEN_TDATA;

  pcap_to_hwgen #(.MAX_PKT_LEN(16384)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .PCAP_TVALID  (PCAP_TVALID),
    .PCAP_TREADY  (PCAP_TREADY),
    .PCAP_TDATA   (PCAP_TDATA),
    .HWGEN_TVALID (HWGEN_TVALID),
    .HWGEN_TREADY (HWGEN_TREADY),
    .HWGEN_TDATA  (HWGEN_TDATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]   file_q[$];
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  logic [127:0] first_q[$];
  int unsigned  stall_q[$];

  int          rdy_mode = 0;
  int unsigned valid_seen;
  bit          saw_in_stall;
  bit          mon_prev_stall = 0;
  logic [127:0] mon_prev_data;

  task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Downstream ready: constant 1, or toggling every cycle.
  initial begin
    HWGEN_TREADY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (rdy_mode == 1) HWGEN_TREADY = !HWGEN_TREADY;
      else HWGEN_TREADY = 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (!RST_N) begin
      mon_prev_stall = 1'b0;
    end else begin
      if (mon_prev_stall) begin
        check128("hold_tvalid", 128'(HWGEN_TVALID), 128'd1);
        check128("hold_tdata", HWGEN_TDATA, mon_prev_data);
      end
      if (HWGEN_TVALID) valid_seen++;
      if (HWGEN_TVALID && HWGEN_TREADY) got_q.push_back(HWGEN_TDATA);
      if (!PCAP_TREADY) saw_in_stall = 1'b1;
      mon_prev_stall = HWGEN_TVALID && !HWGEN_TREADY;
      mon_prev_data  = HWGEN_TDATA;
    end
  end

  task automatic put32(input logic [31:0] v);
    for (int i = 0; i < 4; i++) file_q.push_back(v[8*i +: 8]);
  endtask

  task automatic add_global(input bit magic_ok);
    put32(magic_ok ? 32'hA1B2_C3D4 : 32'hA1B2_3C4D);
    put32(32'h0004_0002);
    put32(32'h0);
    put32(32'h0);
    put32(32'h0000_FFFF);
    put32(32'h1);
  endtask

  // Appends one record to the file and its expected words to exp_q.
  task automatic add_record(input logic [31:0] sec, input logic [31:0] usec,
                            input int unsigned len, input logic [31:0] orig,
                            input int unsigned seed);
    logic [7:0]   pay[$];
    logic [127:0] w;
    put32(sec);
    put32(usec);
    put32(32'(len));
    put32(orig);
    for (int unsigned i = 0; i < len; i++) begin
      pay.push_back(8'((seed * 53 + i * 7 + 11) & 255));
      file_q.push_back(pay[i]);
    end
    exp_q.push_back({sec, usec, orig, 32'(len)});
    for (int unsigned b = 0; b < len; b += 16) begin
      w = '0;
      for (int unsigned k = 0; k < 16; k++) begin
        if (b + k < len) w[8*k +: 8] = pay[b + k];
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic do_reset(input string tag);
    PCAP_TVALID = 1'b0;
    PCAP_TDATA  = '0;
    RST_N       = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      check128({tag, "_rst_hwgen_tvalid"}, 128'(HWGEN_TVALID), 128'd0);
      check128({tag, "_rst_hwgen_tdata"}, HWGEN_TDATA, 128'd0);
      check128({tag, "_rst_pcap_tready"}, 128'(PCAP_TREADY), 128'd0);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic drive_file(input int unsigned max_beats);
    int unsigned  nb;
    int unsigned  stalls;
    logic [127:0] w;
    nb = (file_q.size() + 15) / 16;
    stall_q.delete();
    for (int unsigned b = 0; b < nb && b < max_beats; b++) begin
      w = '0;
      for (int unsigned k = 0; k < 16; k++) begin
        if (16 * b + k < file_q.size()) w[8*k +: 8] = file_q[16 * b + k];
      end
      PCAP_TVALID = 1'b1;
      PCAP_TDATA  = w;
      stalls = 0;
      @(negedge CLK);
      while (!PCAP_TREADY && stalls < 200) begin
        stalls++;
        @(negedge CLK);
      end
      if (!PCAP_TREADY) begin
        n_checks++;
        n_fail++;
        $display("FAIL input_timeout: beat %0d not accepted after %0d cycles", b, stalls);
        PCAP_TVALID = 1'b0;
        return;
      end
      stall_q.push_back(stalls);
      @(posedge CLK);
      #1;
    end
    PCAP_TVALID = 1'b0;
  endtask

  task automatic wait_outputs(input int unsigned n, input int unsigned budget);
    for (int unsigned c = 0; c < budget; c++) begin
      if (got_q.size() >= n) break;
      @(negedge CLK);
    end
    repeat (30) @(negedge CLK);
  endtask

  task automatic compare_words(input string tag, input logic [127:0] ref_q[$]);
    int unsigned n;
    check128({tag, "_word_count"}, 128'(got_q.size()), 128'(ref_q.size()));
    n = (got_q.size() < ref_q.size()) ? got_q.size() : ref_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      check128($sformatf("%s_word%0d", tag, i), got_q[i], ref_q[i]);
    end
  endtask

  typedef struct {
    string       name;
    bit          magic_ok;
    int          rdy_mode;
    int unsigned n_rec;
    int unsigned len0;
    int unsigned len1;
    int unsigned exp_words;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int unsigned max_stall;
    logic [127:0] w;

    RST_N       = 1'b0;
    PCAP_TVALID = 1'b0;
    PCAP_TDATA  = '0;

    vecs[0] = '{name:"rec60",   magic_ok:1'b1, rdy_mode:0, n_rec:1, len0:60,  len1:0,  exp_words:5};
    vecs[1] = '{name:"rec16_17",magic_ok:1'b1, rdy_mode:0, n_rec:2, len0:16,  len1:17, exp_words:5};
    vecs[2] = '{name:"rec0_64", magic_ok:1'b1, rdy_mode:0, n_rec:2, len0:0,   len1:64, exp_words:6};
    vecs[3] = '{name:"badmagic",magic_ok:1'b0, rdy_mode:0, n_rec:2, len0:48,  len1:40, exp_words:0};
    vecs[4] = '{name:"toggle100",magic_ok:1'b1,rdy_mode:1, n_rec:1, len0:100, len1:0,  exp_words:8};

    for (int unsigned vi = 0; vi < 5; vi++) begin
      file_q.delete();
      exp_q.delete();
      add_global(vecs[vi].magic_ok);
      if (vecs[vi].n_rec > 0) add_record(32'd5, 32'd7, vecs[vi].len0, 32'(vecs[vi].len0), 4 * vi);
      if (vecs[vi].n_rec > 1) add_record(32'd6, 32'd107, vecs[vi].len1, 32'(vecs[vi].len1 + 4), 4 * vi + 1);
      if (!vecs[vi].magic_ok) exp_q.delete();

      rdy_mode = 0;
      do_reset(vecs[vi].name);
      got_q.delete();
      valid_seen   = 0;
      saw_in_stall = 1'b0;
      rdy_mode = vecs[vi].rdy_mode;

      drive_file(1000);
      wait_outputs(vecs[vi].exp_words, 400);

      check128({vecs[vi].name, "_table_count"}, 128'(got_q.size()), 128'(vecs[vi].exp_words));
      compare_words(vecs[vi].name, exp_q);

      if (vi == 0 && got_q.size() == 5) begin
        check128("rec60_desc_const", got_q[0], 128'h00000005_00000007_0000003C_0000003C);
        w = got_q[4];
        check128("rec60_last_upper_zero", 128'(w[127:96]), 128'd0);
      end
      if (!vecs[vi].magic_ok) begin
        check128("badmagic_no_tvalid", 128'(valid_seen), 128'd0);
        max_stall = 0;
        for (int unsigned b = 3; b < stall_q.size(); b++) begin
          if (stall_q[b] > max_stall) max_stall = stall_q[b];
        end
        check128("badmagic_beats_sent", 128'(stall_q.size()), 128'((file_q.size() + 15) / 16));
        check128("badmagic_tready_high", 128'(max_stall), 128'd0);
      end
      if (vecs[vi].rdy_mode == 1) begin
        check128("toggle_pcap_tready_low", 128'(saw_in_stall), 128'd1);
      end
    end

    // Reset in the middle of a packet, then replay the whole file.
    rdy_mode = 0;
    file_q.delete();
    exp_q.delete();
    add_global(1'b1);
    add_record(32'd9, 32'd33, 100, 32'd120, 40);
    add_record(32'd10, 32'd44, 17, 32'd17, 41);

    do_reset("replay_a");
    got_q.delete();
    drive_file(1000);
    wait_outputs(exp_q.size(), 400);
    compare_words("replay_first", exp_q);
    first_q = got_q;

    do_reset("replay_b");
    got_q.delete();
    drive_file(4);
    repeat (3) @(negedge CLK);
    check128("mid_data_started", 128'(got_q.size() > 0), 128'd1);
    do_reset("mid_data");
    got_q.delete();
    drive_file(1000);
    wait_outputs(first_q.size(), 400);
    compare_words("replay_second", first_q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcap_to_hwgen.md
Name: pcap_to_hwgen

Overview:
- Streaming parser that converts a raw libpcap file image into a packet stream for the downstream hardware traffic generator.
- Input is the file bytes packed 16 per 128-bit AXI-Stream-like beat.
- Output per packet: one 128-bit descriptor word, then the captured payload realigned to 16-byte words.
- Sits between the pcap file/DMA source and the generator.

Parameters:
- MAX_PKT_LEN, 16384, largest accepted incl_len in bytes; larger values are an error.

Ports:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- PCAP_TVALID  in  1  input beat valid
- PCAP_TREADY  out  1  input beat accepted when TVALID&&TREADY
- PCAP_TDATA  in  128  file bytes; stream byte k of beat at [8k+7:8k] (byte 0 = LSB)
- HWGEN_TVALID  out  1  output word valid
- HWGEN_TREADY  in  1  downstream ready
- HWGEN_TDATA  out  128  descriptor or payload word

Behaviour:
- Clock/reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values:
  - HWGEN_TVALID=0, HWGEN_TDATA=0, PCAP_TREADY=0 while RST_N low.
  - Byte buffer empty (fill=0); FSM in GLOBAL.
- Byte buffer:
  - 32-byte shift buffer with fill count 0..32.
  - PCAP_TREADY = RST_N && (fill<=16), or 1 in ERROR.
  - Accepted beat is appended at offset (fill - bytes consumed this cycle).
  - Consumed bytes are removed from the bottom; the remainder shifts down.
  - Consume and append may occur in the same cycle.
- Output register:
  - May load only when !HWGEN_TVALID || HWGEN_TREADY.
  - HWGEN_TDATA is held stable while TVALID && !TREADY.
  - No combinational path from HWGEN_TREADY to HWGEN_TVALID/TDATA.
- FSM GLOBAL:
  - Wait fill>=24, then consume 24 bytes.
  - Bytes 0..3 must equal D4 C3 B2 A1 (magic 0xA1B2C3D4 little-endian), else go to ERROR.
  - Remaining global-header fields are ignored.
  - Next state REC_HDR.
- FSM REC_HDR:
  - Wait fill>=16, consume 16 bytes.
  - Latch little-endian ts_sec (bytes 0-3), ts_usec (4-7), incl_len (8-11), orig_len (12-15).
  - incl_len > MAX_PKT_LEN -> ERROR; else -> EMIT_HDR.
- FSM EMIT_HDR:
  - When the output register can load, present descriptor: [31:0]=incl_len, [63:32]=orig_len, [95:64]=ts_usec, [127:96]=ts_sec.
  - Set remaining = incl_len.
  - Next state DATA, or REC_HDR if incl_len==0.
- FSM DATA:
  - n = min(16, remaining).
  - When fill>=n and the output register can load: emit bytes 0..n-1 in positions 0..n-1, upper bytes zero; consume n; remaining -= n.
  - When remaining reaches 0, go to REC_HDR.
  - Last word of an L-byte packet carries L mod 16 valid bytes (16 if L is a multiple of 16).
  - Word count per packet = 1 + ceil(L/16).
- Latency: an output word loads the cycle after the enabling condition; minimum 1 cycle from the last required input beat to HWGEN_TVALID.
- ERROR:
  - Sticky until reset.
  - PCAP_TREADY=1, input discarded, HWGEN_TVALID drops after the current word is accepted; no further output.
- End of input:
  - A truncated trailing record (fill below the requirement) stays buffered.
  - Nothing is emitted for it; there is no flush.
- Async reset mid-packet: all state cleared; the next accepted byte is treated as global-header byte 0.
- Backpressure on HWGEN stalls the FSM; the buffer then fills to at most 32 and PCAP_TREADY goes low.

Decomposition:
- Shared package holds:
  - State enum (GLOBAL, REC_HDR, EMIT_HDR, DATA, ERROR).
  - PCAP_MAGIC_LE constant.
  - Header sizes: 24 and 16.
  - Descriptor field offsets.
- One natural sub-module: pcap_byte_aligner, holding the 32-byte buffer, fill count, append/consume shifter and ready generation.
- The FSM and output register stay in the top.

Test Plan:
- Global header plus one 60-byte record (incl_len=orig_len=60, ts 5s/7us), HWGEN_TREADY=1:
  - Descriptor 0x00000005_00000007_0000003C_0000003C.
  - Then 4 data words; the last has bytes 0..11 valid and bytes 12..15 zero.
- Two back-to-back records of lengths 16 and 17, both unaligned to beats:
  - Outputs: desc(16), 1 word; then desc(17), 2 words, the last holding 1 byte.
  - Byte contents match the file exactly.
- incl_len=0 record followed by a 64-byte record:
  - Descriptor with length 0 and no data word.
  - Then desc(64) plus 4 words.
- Wrong magic (bytes 0..3 = 4D 3C B2 A1):
  - No HWGEN_TVALID ever.
  - PCAP_TREADY stays 1 for all subsequent beats.
- HWGEN_TREADY toggling 1/0 every cycle during a 100-byte packet:
  - HWGEN_TDATA stable while stalled.
  - All 1+7 words delivered in order.
  - PCAP_TREADY deasserts when fill>16.
- Assert RST_N low mid-DATA, then replay the full file:
  - Outputs are 0 during reset.
  - After release the output sequence is identical to the first run.
